// File: rtl/int_bus_arb_pkg.sv
// Shared types and helpers for the internal register-bus arbiter.
// State encoding, default bus widths and a constant-width log2 helper.
package int_bus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GRANT    = 2'd1,
        ST_HANDOVER = 2'd2
    } arb_state_t;

    localparam int DEF_AW = 16;
    localparam int DEF_DW = 8;

    function automatic int clog2(input int value);
        int res;
        int v;
        res = 32'sd0;
        v   = value - 32'sd1;
        while (v > 32'sd0) begin
            res = res + 32'sd1;
            v   = v >>> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/int_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: scans eligible requests starting one
// past the pointer and returns the first hit as one-hot plus its index.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [N-1:0]  i_eligible,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_onehot,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    logic [N-1:0] w_hit;

    assign w_hit = i_req & i_eligible;

    // Rotating scan; the first hit after the pointer locks the result.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        for (int k = 1; k <= N; k++) begin
            int  c;
            logic take;
            c           = (int'(i_ptr) + k) % N;
            take        = !o_valid && w_hit[c];
            o_idx       = take ? IW'(c) : o_idx;
            o_onehot[c] = take;
            o_valid     = o_valid | take;
        end
    end

endmodule

// File: rtl/int_bus_arbiter.sv
// Round-robin arbiter sharing the register-file bus between bus masters.
// Optional grant timeout with master masking is enabled by ARB_TIMEOUT_EN.
module int_bus_arbiter
    import int_bus_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int AW             = DEF_AW,
    parameter int DW             = DEF_DW,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_MASTERS-1:0]    m_req,
    output logic [NUM_MASTERS-1:0]    m_gnt,
    input  logic [NUM_MASTERS*AW-1:0] m_address,
    input  logic [NUM_MASTERS*DW-1:0] m_wr_data,
    input  logic [NUM_MASTERS-1:0]    m_write,
    input  logic [NUM_MASTERS-1:0]    m_read,
    output logic [DW-1:0]             m_rd_data,
    output logic [AW-1:0]             reg_address,
    output logic [DW-1:0]             reg_wr_data,
    output logic                      reg_write,
    output logic                      reg_read,
    input  logic [DW-1:0]             reg_rd_data,
    output logic                      timeout_err
);

    localparam int IW = clog2(NUM_MASTERS);

    arb_state_t             r_state;
    arb_state_t             w_state_nxt;
    logic [NUM_MASTERS-1:0] r_gnt;
    logic [NUM_MASTERS-1:0] w_gnt_nxt;
    logic [IW-1:0]          r_ptr;
    logic [IW-1:0]          w_ptr_nxt;
    logic [IW-1:0]          r_owner;
    logic [IW-1:0]          w_owner_nxt;
    logic                   r_terr;
    logic                   w_terr_nxt;
    logic [NUM_MASTERS-1:0] w_eligible;
    logic                   w_timeout;
    logic                   w_owner_req;
    logic                   w_has_gnt;
    logic [NUM_MASTERS-1:0] w_pick_onehot;
    logic [IW-1:0]          w_pick_idx;
    logic                   w_pick_valid;

    rr_pick #(
        .N  (NUM_MASTERS),
        .IW (IW)
    ) u_rr_pick (
        .i_req      (m_req),
        .i_eligible (w_eligible),
        .i_ptr      (r_ptr),
        .o_onehot   (w_pick_onehot),
        .o_idx      (w_pick_idx),
        .o_valid    (w_pick_valid)
    );

    assign w_owner_req = |(m_req & r_gnt);

`ifdef ARB_TIMEOUT_EN
    localparam int CW = clog2(TIMEOUT_CYCLES) + 1;

    logic [CW-1:0]          r_cnt;
    logic [NUM_MASTERS-1:0] r_mask;

    assign w_timeout  = (r_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign w_eligible = m_req & ~r_mask;

    // Grant-length counter and per-master mask after a revoked grant.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_mask <= '0;
        end else begin
            if (r_state == ST_GRANT) begin
                r_cnt <= r_cnt + CW'(1);
            end else begin
                r_cnt <= '0;
            end
            // A master stays masked until it has dropped its request once.
            r_mask <= (r_mask & m_req) | (w_terr_nxt ? r_gnt : '0);
        end
    end
`else
    assign w_timeout  = 1'b0;
    assign w_eligible = m_req;
`endif

    // Next-state and next-grant decode.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_terr_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_gnt_nxt   = w_pick_onehot;
                    w_ptr_nxt   = w_pick_idx;
                    w_owner_nxt = w_pick_idx;
                    w_state_nxt = ST_GRANT;
                end else begin
                    w_gnt_nxt   = '0;
                end
            end
            ST_GRANT: begin
                if (!w_owner_req) begin
                    w_gnt_nxt   = '0;
                    w_state_nxt = ST_HANDOVER;
                end else if (w_timeout) begin
                    w_gnt_nxt   = '0;
                    w_terr_nxt  = 1'b1;
                    w_state_nxt = ST_HANDOVER;
                end else begin
                    w_gnt_nxt   = r_gnt;
                end
            end
            ST_HANDOVER: begin
                w_gnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_gnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Arbiter state register; the pointer starts at the last master so
    // master 0 wins the first arbitration.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_ptr   <= IW'(NUM_MASTERS - 1);
            r_owner <= '0;
            r_terr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
            r_terr  <= w_terr_nxt;
        end
    end

    // Datapath is gated by the registered grant, so reset silences it at once.
    assign w_has_gnt   = |r_gnt;
    assign reg_address = w_has_gnt ? m_address[int'(r_owner)*AW +: AW] : '0;
    assign reg_wr_data = w_has_gnt ? m_wr_data[int'(r_owner)*DW +: DW] : '0;
    assign reg_write   = |(m_write & r_gnt);
    assign reg_read    = |(m_read & r_gnt);
    assign m_rd_data   = reg_rd_data;
    assign m_gnt       = r_gnt;
    assign timeout_err = r_terr;

endmodule

// File: tb/tb_int_bus_arbiter.sv
// Self-checking bench for int_bus_arbiter: directed table, corner sequences
// and randomized traffic against a behavioural model.
module tb_int_bus_arbiter;

    localparam int N  = 2;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int TO = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic [N-1:0]      m_req, m_gnt, m_write, m_read;
    logic [N*AW-1:0]   m_address;
    logic [N*DW-1:0]   m_wr_data;
    logic [DW-1:0]     m_rd_data, reg_wr_data, reg_rd_data;
    logic [AW-1:0]     reg_address;
    logic              reg_write, reg_read, timeout_err;

    int checks   = 0;
    int failures = 0;

    // model: who owns the bus, who won last, dead-cycle flag, cycles held
    int mo_owner, mo_last, mo_hold;
    bit mo_dead, mo_err;
    bit mo_mask [N];

    always #5 clock = ~clock;

    int_bus_arbiter #(
        .NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock), .reset(reset), .m_req(m_req), .m_gnt(m_gnt),
        .m_address(m_address), .m_wr_data(m_wr_data), .m_write(m_write),
        .m_read(m_read), .m_rd_data(m_rd_data), .reg_address(reg_address),
        .reg_wr_data(reg_wr_data), .reg_write(reg_write), .reg_read(reg_read),
        .reg_rd_data(reg_rd_data), .timeout_err(timeout_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mo_owner = -1;
        mo_last  = N - 1;
        mo_hold  = 0;
        mo_dead  = 1'b0;
        mo_err   = 1'b0;
        for (int i = 0; i < N; i++) mo_mask[i] = 1'b0;
    endtask

    task automatic model_edge();
        if (!reset) begin
            model_reset();
            return;
        end
        mo_err = 1'b0;
        if (mo_owner >= 0) begin
            if (!m_req[mo_owner]) begin
                mo_owner = -1;
                mo_dead  = 1'b1;
            end else if (TO_EN && mo_hold == TO - 1) begin
                mo_mask[mo_owner] = 1'b1;
                mo_owner = -1;
                mo_dead  = 1'b1;
                mo_err   = 1'b1;
            end else begin
                mo_hold++;
            end
        end else if (mo_dead) begin
            mo_dead = 1'b0;
        end else begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (mo_last + k) % N;
                if (m_req[c] && !mo_mask[c]) begin
                    mo_owner = c;
                    mo_last  = c;
                    mo_hold  = 0;
                    break;
                end
            end
        end
        for (int i = 0; i < N; i++) if (!m_req[i]) mo_mask[i] = 1'b0;
    endtask

    task automatic check_model();
        logic [N-1:0]  e_gnt;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        logic          e_wr, e_rd;
        e_gnt = '0; e_addr = '0; e_wd = '0; e_wr = 1'b0; e_rd = 1'b0;
        if (mo_owner >= 0) begin
            e_gnt[mo_owner] = 1'b1;
            e_addr = m_address[mo_owner*AW +: AW];
            e_wd   = m_wr_data[mo_owner*DW +: DW];
            e_wr   = m_write[mo_owner];
            e_rd   = m_read[mo_owner];
        end
        chk("model{gnt,wr,rd,addr,wd,rdd,err}",
            {m_gnt, reg_write, reg_read, reg_address, reg_wr_data, m_rd_data, timeout_err},
            {e_gnt, e_wr, e_rd, e_addr, e_wd, reg_rd_data, mo_err});
    endtask

    task automatic advance();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    typedef struct {
        logic [N-1:0]  req, wr, rd;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1, rdd;
        logic [N-1:0]  egnt;
        logic          ewr, erd;
        logic [AW-1:0] eaddr;
        logic [DW-1:0] ewd;
    } vec_t;

    vec_t tbl [11];
    bit   found;
    int   n_g0, n_g1, n_err;

    initial begin
        tbl[0]  = '{2'b11, 2'b00, 2'b00, 16'h1234, 16'hBEEF, 8'h11, 8'h5A, 8'h00, 2'b01, 1'b0, 1'b0, 16'h1234, 8'h11};
        tbl[1]  = '{2'b11, 2'b11, 2'b00, 16'h0010, 16'hBEEF, 8'hA5, 8'h5A, 8'h00, 2'b01, 1'b1, 1'b0, 16'h0010, 8'hA5};
        tbl[2]  = '{2'b11, 2'b10, 2'b00, 16'h0010, 16'hBEEF, 8'hA5, 8'h5A, 8'h00, 2'b01, 1'b0, 1'b0, 16'h0010, 8'hA5};
        tbl[3]  = '{2'b10, 2'b01, 2'b00, 16'h0010, 16'hBEEF, 8'hA5, 8'h5A, 8'h00, 2'b01, 1'b1, 1'b0, 16'h0010, 8'hA5};
        tbl[4]  = '{2'b11, 2'b00, 2'b00, 16'h0010, 16'hBEEF, 8'hA5, 8'h5A, 8'h00, 2'b00, 1'b0, 1'b0, 16'h0000, 8'h00};
        tbl[5]  = '{2'b11, 2'b00, 2'b00, 16'h0010, 16'hBEEF, 8'hA5, 8'h5A, 8'h00, 2'b00, 1'b0, 1'b0, 16'h0000, 8'h00};
        tbl[6]  = '{2'b11, 2'b00, 2'b10, 16'h0010, 16'hBEEF, 8'hA5, 8'h5A, 8'h3C, 2'b10, 1'b0, 1'b1, 16'hBEEF, 8'h5A};
        tbl[7]  = '{2'b01, 2'b00, 2'b10, 16'h0010, 16'hBEEF, 8'hA5, 8'h5A, 8'h3C, 2'b10, 1'b0, 1'b1, 16'hBEEF, 8'h5A};
        tbl[8]  = '{2'b01, 2'b00, 2'b11, 16'h0010, 16'hBEEF, 8'hA5, 8'h5A, 8'h3C, 2'b00, 1'b0, 1'b0, 16'h0000, 8'h00};
        tbl[9]  = '{2'b01, 2'b00, 2'b00, 16'h0010, 16'hBEEF, 8'hA5, 8'h5A, 8'h00, 2'b00, 1'b0, 1'b0, 16'h0000, 8'h00};
        tbl[10] = '{2'b01, 2'b00, 2'b00, 16'h0010, 16'hBEEF, 8'hA5, 8'h5A, 8'h00, 2'b01, 1'b0, 1'b0, 16'h0010, 8'hA5};

        reset = 1'b0; m_req = 2'b11; m_write = '0; m_read = '0;
        m_address = {16'hBEEF, 16'h1234}; m_wr_data = {8'h5A, 8'h11}; reg_rd_data = '0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("reset_gnt", {m_gnt, timeout_err}, 3'b000);
            advance();
        end
        reset = 1'b1;
        @(negedge clock); check_model(); advance();

        for (int i = 0; i < 11; i++) begin
            m_req = tbl[i].req; m_write = tbl[i].wr; m_read = tbl[i].rd;
            m_address = {tbl[i].a1, tbl[i].a0}; m_wr_data = {tbl[i].d1, tbl[i].d0};
            reg_rd_data = tbl[i].rdd;
            @(negedge clock);
            chk($sformatf("tbl%0d", i),
                {m_gnt, reg_write, reg_read, reg_address, reg_wr_data, m_rd_data},
                {tbl[i].egnt, tbl[i].ewr, tbl[i].erd, tbl[i].eaddr, tbl[i].ewd, tbl[i].rdd});
            check_model();
            advance();
        end

        // reset in the middle of master 1's grant, then priority returns to master 0
        m_req = 2'b10; found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clock); check_model();
            if (m_gnt == 2'b10) found = 1'b1;
            else advance();
        end
        chk("wait_gnt1", found, 1);
        m_write = 2'b11; m_read = 2'b11;
        #1 chk("gnt1_write", {reg_write, reg_read}, 2'b11);
        #1 reset = 1'b0;
        #1 chk("async_reset", {m_gnt, reg_write, reg_read}, 4'b0000);
        model_reset();
        advance();
        reset = 1'b1; m_req = 2'b11; m_write = '0; m_read = '0;
        @(negedge clock); check_model(); advance();
        @(negedge clock); chk("reset_priority", m_gnt, 2'b01); check_model(); advance();

`ifdef ARB_TIMEOUT_EN
        reset = 1'b0; #1 model_reset();
        @(negedge clock); check_model(); advance();
        reset = 1'b1; n_g0 = 0; n_g1 = 0; n_err = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            n_g0 += int'(m_gnt[0]); n_g1 += int'(m_gnt[1]); n_err += int'(timeout_err);
            check_model(); advance();
        end
        chk("to_hold0", n_g0, TO);
        chk("to_hold1", n_g1, TO);
        chk("to_errs", n_err, 2);
        m_req = 2'b10;
        @(negedge clock); check_model(); advance();
        m_req = 2'b11; found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            @(negedge clock); check_model();
            if (m_gnt == 2'b01) found = 1'b1;
            advance();
        end
        chk("to_regrant0", found, 1);
`endif

        for (int i = 0; i < 600; i++) begin
            for (int m = 0; m < N; m++) if ($urandom_range(0, 5) == 0) m_req[m] = ~m_req[m];
            m_write     = N'($urandom);
            m_read      = N'($urandom);
            m_address   = (N*AW)'($urandom);
            m_wr_data   = (N*DW)'($urandom);
            reg_rd_data = DW'($urandom);
            @(negedge clock); check_model(); advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/int_bus_arbiter.md
Name: int_bus_arbiter

Overview:
Round-robin arbiter sharing the internal register-file bus between several bus masters: the uart2bus parser plus local masters such as a debug or self-test sequencer. Each master raises a request and waits for a grant. The arbiter then routes that master's address, data and strobes to the single register-file port, and broadcasts read data back. It sits between the uart2bus top and the register file.

Parameters:
NUM_MASTERS, 2, number of requesting masters (2..8)
AW, 16, address width
DW, 8, data width
TIMEOUT_CYCLES, 1024, maximum grant hold length; used only with ARB_TIMEOUT_EN

Ports:
clock  in  1  global clock
reset  in  1  asynchronous, active-low reset
m_req  in  NUM_MASTERS  per-master bus request; held for the whole access sequence
m_gnt  out  NUM_MASTERS  per-master grant, one-hot or zero, registered
m_address  in  NUM_MASTERS*AW  packed addresses; master i occupies bits [i*AW +: AW]
m_wr_data  in  NUM_MASTERS*DW  packed write data
m_write  in  NUM_MASTERS  per-master write strobe
m_read  in  NUM_MASTERS  per-master read strobe
m_rd_data  out  DW  read data broadcast to all masters
reg_address  out  AW  register-file address
reg_wr_data  out  DW  register-file write data
reg_write  out  1  register-file write strobe
reg_read  out  1  register-file read strobe
reg_rd_data  in  DW  register-file read data
timeout_err  out  1  one-cycle pulse when a grant is revoked by timeout

Behaviour:
- Reset (reset low, asynchronous): m_gnt=0, state=IDLE, last-grant pointer=NUM_MASTERS-1 (master 0 wins first), timeout_err=0. reg_write/reg_read are forced to 0 immediately because they are gated by m_gnt.
- States:
  - IDLE: if any eligible m_req bit is high, pick the winner, set m_gnt[winner] on the next edge, update the pointer and go to GRANT.
  - GRANT: hold m_gnt while m_req[owner] stays high. When m_req[owner] falls, clear m_gnt on the next edge and go to HANDOVER.
  - HANDOVER: a single dead cycle with m_gnt=0, then go to IDLE. This guarantees no back-to-back grants and no strobe overlap between owners.
- Arbitration: search starts at pointer+1 modulo NUM_MASTERS; the first set eligible request wins. Simultaneous requests resolve strictly in rotation.
- Latency: request in IDLE to grant is 1 cycle. Minimum gap between two owners is 2 cycles (grant drop plus HANDOVER).
- Datapath is combinational from the owner's inputs:
  - reg_address = owner address, or 0 when no grant.
  - reg_wr_data = owner write data, or 0 when no grant.
  - reg_write = |(m_write & m_gnt); reg_read = |(m_read & m_gnt).
  - Strobes from non-granted masters are ignored.
- m_rd_data = reg_rd_data unconditionally. The register file's read timing is unchanged.
- A master that asserts a strobe without a grant gets no effect; no error is flagged.
- If m_req[owner] drops while m_write is still high, the write is still passed combinationally in that cycle. The grant clears on the next edge.
- The pointer updates only on a new grant, not on release.

Optional Feature:
ARB_TIMEOUT_EN
- With it defined:
  - An internal counter clears on grant and increments every GRANT cycle.
  - When it reaches TIMEOUT_CYCLES-1 with req still high, m_gnt clears on the next edge and timeout_err pulses high for 1 cycle.
  - State goes to HANDOVER.
  - The offending master is masked (not eligible) until it deasserts m_req for at least one cycle.
- Without it: no counter, no mask logic; timeout_err is tied to 0 and grants are unbounded.

Decomposition:
- Package int_bus_arb_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_GRANT=2'd1, ST_HANDOVER=2'd2;
  - the default AW/DW;
  - the counter-width function clog2.
- One sub-module, rr_pick: combinational round-robin picker taking requests, the eligible mask and the pointer, and producing a one-hot winner plus its index.

Test Plan:
1. Reset low, m_req=2'b11 → m_gnt=0 during reset. After release, m_gnt=2'b01 one cycle later; reg_address equals master 0's address (e.g. 16'h1234).
2. Master 0 holds req and writes 8'hA5 to 16'h0010 while master 1 drives m_write=1 → reg_write=1, reg_wr_data=8'hA5. Master 1's strobe has no effect.
3. Both requesting continuously, each releasing after 4 cycles → grants alternate 01, 10, 01 with exactly 2 no-grant cycles between owners.
4. Master 1 granted, reg_rd_data=8'h3C, m_read=2'b10 → reg_read=1 and m_rd_data=8'h3C seen by both masters.
5. Assert reset mid-grant → m_gnt, reg_write and reg_read drop to 0 asynchronously. After release, master 0 has priority again.
6. ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8, master 0 holding req → grant revoked after 8 cycles with a 1-cycle timeout_err pulse. Master 1 is granted next; master 0 is not re-granted until it toggles req.
